mul_add: RTL and testbench

//   Sequential signed multiply-accumulate: P = X*Y + Z, one partial product per clock.
//   It is the inverse partner of the calc divider: feeding it the divider's Q, B and R

---
 rtl/mul_add_if.sv | 25 ++
 rtl/mul_add.sv | 98 +++++++++
 tb/tb_mul_add.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mul_add_if.sv
// Operand/result bundle for mul_add: X*Y+Z request with the idle-high output_vld handshake.
interface mul_add_if #(
  parameter int BITS = 4
);
  logic signed [BITS-1:0]   X;
  logic signed [BITS-1:0]   Y;
  logic signed [BITS-1:0]   Z;
  logic                     input_vld;
  logic signed [2*BITS-1:0] P;
  logic                     ovf;
  logic                     output_vld;

  // Handshake: output_vld=1 means idle with P/ovf holding the last result; a start is
  // taken on any rising edge where output_vld=1 and input_vld=1, and X/Y/Z are sampled
  // only on that edge. input_vld while output_vld=0 is ignored, never queued.
  modport master (
    output X, Y, Z, input_vld,
    input  P, ovf, output_vld
  );

  modport slave (
    input  X, Y, Z, input_vld,
    output P, ovf, output_vld
  );
endinterface

// File: rtl/mul_add.sv
// Sequential signed multiply-accumulate P = X*Y + Z, one partial product per clock.
// Rebuilds the divider's dividend from its Q, B and R; latency is BITS+2 cycles.
module mul_add #(
  parameter int BITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_add_if.slave   bus,
  output logic [1:0] fsm_state
);
  localparam int W = 2 * BITS;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACTIVE   = 2'd1;
  localparam logic [1:0] SIGN_FIX = 2'd2;
  localparam logic [1:0] ADD      = 2'd3;

  logic [1:0]      state;
  logic [BITS-1:0] mag_x;
  logic [BITS-1:0] mag_y;
  logic            p_neg;
  logic [W-1:0]    zext;
  logic [W-1:0]    acc;
  logic [4:0]      bitidx;
  logic [W-1:0]    p_q;
  logic            ovf_q;

  logic [BITS-1:0] y_shr;
  logic [W-1:0]    partial;
  logic [W-1:0]    sum;
  logic            sum_ovf;

  // The most negative operand maps to 2^(BITS-1), which still fits unsigned BITS bits.
  function automatic logic [BITS-1:0] magnitude(input logic [BITS-1:0] v);
    magnitude = v[BITS-1] ? (~v + {{(BITS-1){1'b0}}, 1'b1}) : v;
  endfunction

  always_comb begin
    y_shr   = mag_y >> bitidx;
    partial = '0;
    if (y_shr[0]) partial = {{BITS{1'b0}}, mag_x} << bitidx;
    sum     = acc + zext;
    // Result fits BITS signed only if the top BITS+1 bits are all copies of the sign.
    sum_ovf = !((&sum[W-1:BITS-1]) || !(|sum[W-1:BITS-1]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mag_x  <= '0;
      mag_y  <= '0;
      p_neg  <= 1'b0;
      zext   <= '0;
      acc    <= '0;
      bitidx <= '0;
      p_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.input_vld) begin
            mag_x  <= magnitude(bus.X);
            mag_y  <= magnitude(bus.Y);
            p_neg  <= bus.X[BITS-1] ^ bus.Y[BITS-1];
            zext   <= {{BITS{bus.Z[BITS-1]}}, bus.Z};
            acc    <= '0;
            bitidx <= 5'(BITS - 1);
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          acc <= acc + partial;
          if (bitidx == 5'd0) begin
            state <= SIGN_FIX;
          end else begin
            bitidx <= bitidx - 5'd1;
          end
        end
        SIGN_FIX: begin
          if (p_neg) acc <= ~acc + {{(W-1){1'b0}}, 1'b1};
          p_neg <= 1'b0;
          state <= ADD;
        end
        ADD: begin
          p_q   <= sum;
          ovf_q <= sum_ovf;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.P          = p_q;
  assign bus.ovf        = ovf_q;
  assign bus.output_vld = (state == IDLE);
  assign fsm_state      = state;
endmodule

// File: tb/tb_mul_add.sv
// Bench for mul_add (BITS=4): directed vectors plus model-checked random runs,
// checked by a monitor that pops an expected queue on every output_vld rise.
module tb_mul_add;
  localparam int BITS = 4;
  localparam int W    = 2 * BITS + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] fsm_state;

  mul_add_if #(.BITS(BITS)) bus ();

  mul_add #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;
  logic         prev_vld = 1'b1;
  int           busy_cnt = 0;

  int           dx[8]   = '{3, -2, -7, -8, -8, 0, 7, -8};
  int           dy[8]   = '{5, 2, 2, -8, 1, 0, 7, 7};
  int           dz[8]   = '{2, -1, -1, 7, 0, 0, 7, -8};
  logic [W-1:0] dexp[8] = '{9'h111, 9'h0FB, 9'h1F1, 9'h147, 9'h0F8, 9'h000, 9'h138, 9'h1C0};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: result and latency on each output_vld rise, held {ovf,P} on every other cycle.
  initial begin : monitor
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b1;
        busy_cnt = 0;
      end else if (!bus.output_vld) begin
        busy_cnt++;
        check("hold_busy", {bus.ovf, bus.P}, last_exp);
        prev_vld = 1'b0;
      end else begin
        if (!prev_vld) begin
          check("latency", W'(busy_cnt), W'(BITS + 2));
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL result: unexpected output %h, expected none", {bus.ovf, bus.P});
          end else begin
            exp = exp_q.pop_front();
            check("result", {bus.ovf, bus.P}, exp);
            last_exp = exp;
          end
        end else begin
          check("hold_idle", {bus.ovf, bus.P}, last_exp);
        end
        busy_cnt = 0;
        prev_vld = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.output_vld) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: output_vld=0, expected 1 within 50 cycles");
    end
  endtask

  task automatic run_op(input logic signed [3:0] x, input logic signed [3:0] y,
                        input logic signed [3:0] z, input logic [W-1:0] exp);
    wait_idle();
    bus.X = x;
    bus.Y = y;
    bus.Z = z;
    bus.input_vld = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #2;
    bus.input_vld = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic signed [3:0] xv, yv, zv;
    int                p;
    logic              ov;
    bus.X = '0;
    bus.Y = '0;
    bus.Z = '0;
    bus.input_vld = 1'b0;

    // Reset values, then idle hold with input_vld=0.
    repeat (2) @(posedge clk);
    #2;
    check("rst_p", W'(bus.P), W'(0));
    check("rst_ovf", W'(bus.ovf), W'(0));
    check("rst_vld", W'(bus.output_vld), W'(1));
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    for (int i = 0; i < 8; i++) run_op(4'(dx[i]), 4'(dy[i]), 4'(dz[i]), dexp[i]);

    // input_vld held through a run with operands changed mid-run; next run starts at once.
    wait_idle();
    bus.X = 4'sd1;
    bus.Y = 4'sd2;
    bus.Z = 4'sd3;
    bus.input_vld = 1'b1;
    exp_q.push_back(9'h005);
    @(posedge clk);
    #2;
    bus.X = 4'sd2;
    bus.Y = 4'sd3;
    bus.Z = 4'sd1;
    exp_q.push_back(9'h007);
    wait_idle();
    @(posedge clk);
    #2;
    check("b2b_start", W'(bus.output_vld), W'(0));
    bus.X = -4'sd1;
    bus.Y = -4'sd1;
    bus.Z = -4'sd1;
    bus.input_vld = 1'b0;

    // Reset pulsed in ACTIVE cycle 2 discards the run.
    wait_idle();
    bus.X = 4'sd3;
    bus.Y = 4'sd5;
    bus.Z = 4'sd2;
    bus.input_vld = 1'b1;
    @(posedge clk);
    #2;
    bus.input_vld = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_exp = '0;
    #1;
    check("midrst_p", W'(bus.P), W'(0));
    check("midrst_ovf", W'(bus.ovf), W'(0));
    check("midrst_vld", W'(bus.output_vld), W'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_op(-4'sd2, 4'sd2, -4'sd1, 9'h0FB);

    for (int i = 0; i < 1000; i++) begin
      xv = 4'($urandom_range(0, 15));
      yv = 4'($urandom_range(0, 15));
      zv = 4'($urandom_range(0, 15));
      p  = int'(xv) * int'(yv) + int'(zv);
      ov = (p > 7) || (p < -8);
      run_op(xv, yv, zv, {ov, 8'(p)});
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
